axis_read_ctrl: RTL and testbench

//  Sequencer for one stream-read channel. Accepts a (start address, length) job and splits it into
//  AXI read-address bursts: <= BURST_MAX beats each, never crossing a 4 KB boundary. Before the

---
 rtl/axis_read_ctrl.sv | 163 ++++++++++++++++
 tb/tb_axis_read_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_read_ctrl.sv
// axis_read_ctrl: sequencer for one stream-read channel.
// Takes a (start address, length) job. It first passes the job length to the
// downstream data unit. It then issues AXI read-address bursts of at most
// BURST_MAX beats each, and no burst crosses a 4 KB page.
module axis_read_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CONFIG_DWIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned WIDTH_RATIO    = 8,
    parameter int unsigned BURST_MAX      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    cfg_address,
    input  logic [CONFIG_DWIDTH-1:0] cfg_length,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic [CONFIG_DWIDTH-1:0] dat_length,
    output logic                     dat_valid,
    input  logic                     dat_ready,
    output logic [ADDR_WIDTH-1:0]    axi_araddr,
    output logic [3:0]               axi_arlen,
    output logic                     axi_arvalid,
    input  logic                     axi_arready,
    output logic                     busy
);

    localparam int unsigned BPB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned BPB_LG = $clog2(BPB);
    localparam int unsigned WR_LG  = $clog2(WIDTH_RATIO);
    localparam int unsigned NW     = $clog2(BURST_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0]    ADDR_MASK = ~ADDR_WIDTH'(BPB - 1);
    localparam logic [CONFIG_DWIDTH-1:0] WR_MASK   = CONFIG_DWIDTH'(WIDTH_RATIO - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CALC,
        S_ADDR
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [CONFIG_DWIDTH-1:0] remain_q, remain_d;
    logic [NW-1:0]            n_q, n_d;
    logic [CONFIG_DWIDTH-1:0] dat_length_q, dat_length_d;
    logic [ADDR_WIDTH-1:0]    araddr_q, araddr_d;
    logic [3:0]               arlen_q, arlen_d;
    logic                     arvalid_q, arvalid_d;
    logic                     dat_valid_q, dat_valid_d;
    logic                     cfg_ready_q, cfg_ready_d;
    logic                     busy_q, busy_d;

    logic [CONFIG_DWIDTH-1:0] beats;
    logic [12:0]              page_bytes;
    logic [12:0]              page_beats;
    logic [CONFIG_DWIDTH-1:0] n_calc;

    // Next-state, burst sizing and registered-output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        n_d          = n_q;
        dat_length_d = dat_length_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;

        // Job length in AXI beats, rounded up
        beats = (cfg_length >> WR_LG)
              + {{(CONFIG_DWIDTH-1){1'b0}}, |(cfg_length & WR_MASK)};

        // Beats left before the next 4 KB page boundary (addr is beat aligned)
        page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
        page_beats = page_bytes >> BPB_LG;

        n_calc = CONFIG_DWIDTH'(BURST_MAX);
        if (remain_q < n_calc) begin
            n_calc = remain_q;
        end
        if (CONFIG_DWIDTH'(page_beats) < n_calc) begin
            n_calc = CONFIG_DWIDTH'(page_beats);
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    addr_d   = cfg_address & ADDR_MASK;
                    remain_d = beats;
                    // A zero-length job is consumed here with no downstream activity
                    if (cfg_length != '0) begin
                        dat_length_d = cfg_length;
                        state_d      = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (dat_ready) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                n_d      = NW'(n_calc);
                araddr_d = addr_q;
                arlen_d  = 4'(n_calc - CONFIG_DWIDTH'(1));
                state_d  = S_ADDR;
            end
            S_ADDR: begin
                if (axi_arready) begin
                    addr_d   = addr_q + (ADDR_WIDTH'(n_q) << BPB_LG);
                    remain_d = remain_q - CONFIG_DWIDTH'(n_q);
                    state_d  = (remain_d == '0) ? S_IDLE : S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are decoded from the next state so that they come out registered
        dat_valid_d = (state_d == S_DATA);
        arvalid_d   = (state_d == S_ADDR);
        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            n_q          <= '0;
            dat_length_q <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            dat_valid_q  <= 1'b0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            n_q          <= n_d;
            dat_length_q <= dat_length_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            dat_valid_q  <= dat_valid_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign dat_length  = dat_length_q;
    assign dat_valid   = dat_valid_q;
    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arvalid = arvalid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_axis_read_ctrl.sv
// Scoreboard bench for axis_read_ctrl.
// The stimulus process pushes the expected dat/AR transfers. A negedge monitor
// pops and compares them on each handshake.
module tb_axis_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_address = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] dat_length;
    logic        dat_valid;
    logic        dat_ready = 1'b1;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arlen;
    logic        axi_arvalid;
    logic        axi_arready = 1'b1;
    logic        busy;

    axis_read_ctrl #(
        .ADDR_WIDTH(32),
        .CONFIG_DWIDTH(32),
        .AXI_DATA_WIDTH(256),
        .WIDTH_RATIO(8),
        .BURST_MAX(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_address(cfg_address),
        .cfg_length(cfg_length),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .dat_length(dat_length),
        .dat_valid(dat_valid),
        .dat_ready(dat_ready),
        .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_dat[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Per-job timing recorded by the monitor (edge index of each handshake)
    int dat_edge = -1;
    int ar_first = -1;
    int ar_last = -1;
    int ar_gap_min = 0;
    int ar_gap_max = 0;

    logic ar_stall = 1'b0;
    logic dat_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Edge counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready drivers. When stalling, arready waits 5 cycles and dat_ready waits 3 cycles.
    initial begin
        int ar_cnt = 0;
        int d_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (axi_arvalid) ar_cnt++; else ar_cnt = 0;
            if (dat_valid) d_cnt++; else d_cnt = 0;
            axi_arready = !ar_stall || (axi_arvalid && ar_cnt > 5);
            dat_ready   = !dat_stall || (dat_valid && d_cnt > 3);
        end
    end

    // Monitor: scoreboard pops, hold-stability and cfg_ready exclusion
    initial begin
        logic        p_ar_pend = 1'b0;
        logic        p_dat_pend = 1'b0;
        logic [31:0] p_araddr = '0;
        logic [3:0]  p_arlen = '0;
        logic [31:0] p_dlen = '0;
        ar_t         e;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (p_ar_pend) begin
                    check("ar_hold", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, p_araddr, p_arlen});
                end
                if (p_dat_pend) begin
                    check("dat_hold", {dat_valid, dat_length}, {1'b1, p_dlen});
                end
                if (dat_valid || axi_arvalid) begin
                    check("cfg_ready_busy_while_active", {cfg_ready, busy}, 2'b01);
                end
                if (dat_valid && dat_ready) begin
                    if (exp_dat.size() == 0) begin
                        total_cnt++;
                        $display("FAIL dat_unexpected: got dat_length=%0d, want no transfer", dat_length);
                    end else begin
                        ed = exp_dat.pop_front();
                        check("dat_length", dat_length, ed);
                        dat_edge = cyc + 1;
                    end
                end
                if (axi_arvalid && axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        total_cnt++;
                        $display("FAIL ar_unexpected: got araddr=0x%0h arlen=%0d, want no request", axi_araddr, axi_arlen);
                    end else begin
                        e = exp_ar.pop_front();
                        check("araddr", axi_araddr, e.addr);
                        check("arlen", axi_arlen, e.len);
                    end
                    if (ar_first < 0) begin
                        ar_first = cyc + 1;
                    end else begin
                        if (ar_gap_min == 0 || (cyc + 1 - ar_last) < ar_gap_min) ar_gap_min = cyc + 1 - ar_last;
                        if ((cyc + 1 - ar_last) > ar_gap_max) ar_gap_max = cyc + 1 - ar_last;
                    end
                    ar_last = cyc + 1;
                end
            end
            p_ar_pend  = !rst && axi_arvalid && !axi_arready;
            p_dat_pend = !rst && dat_valid && !dat_ready;
            p_araddr   = axi_araddr;
            p_arlen    = axi_arlen;
            p_dlen     = dat_length;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic push_ar(input logic [31:0] a, input logic [3:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    // Offers a job; returns the edge index at which it was accepted
    task automatic issue(input logic [31:0] a, input logic [31:0] l, output int k);
        int n = 0;
        dat_edge = -1;
        ar_first = -1;
        ar_last = -1;
        ar_gap_min = 0;
        ar_gap_max = 0;
        while (!cfg_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cfg_ready_before_issue", cfg_ready, 1'b1);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!cfg_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, n < 1000, 1'b1);
        check({tag, "_ars_left_at_ready"}, exp_ar.size(), 0);
        check({tag, "_dat_left_at_ready"}, exp_dat.size(), 0);
        check({tag, "_ready_edge"}, cyc, ar_last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
        check({tag, "_dat_valid"}, dat_valid, 1'b0);
        check({tag, "_arvalid"}, axi_arvalid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_araddr"}, axi_araddr, 32'h0);
        check({tag, "_arlen"}, axi_arlen, 4'h0);
        check({tag, "_dat_length"}, dat_length, 32'h0);
    endtask

    initial begin
        int k;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 10 words -> 2 beats, one burst; latency handshake k -> dat k+1 -> AR k+3
        exp_dat.push_back(32'd10);
        push_ar(32'h1000, 4'd1);
        issue(32'h1000, 32'd10, k);
        wait_done("t1");
        check("t1_dat_latency", dat_edge - k, 1);
        check("t1_ar_latency", ar_first - k, 3);

        // 2: 4092 words -> 512 beats -> 32 full bursts, one every 2 cycles
        exp_dat.push_back(32'd4092);
        for (int i = 0; i < 32; i++) push_ar(32'(i) * 32'h200, 4'd15);
        issue(32'h0, 32'd4092, k);
        wait_done("t2");
        check("t2_ar_latency", ar_first - k, 3);
        check("t2_gap_min", ar_gap_min, 2);
        check("t2_gap_max", ar_gap_max, 2);

        // 3: 160 words = 20 beats starting 2 beats below a 4 KB boundary
        exp_dat.push_back(32'd160);
        push_ar(32'h0FC0, 4'd1);
        push_ar(32'h1000, 4'd15);
        push_ar(32'h1200, 4'd1);
        issue(32'h0FC0, 32'd160, k);
        wait_done("t3");

        // 3b: unaligned address low bits dropped; 17 words -> 3 beats
        exp_dat.push_back(32'd17);
        push_ar(32'h5000, 4'd2);
        issue(32'h5013, 32'd17, k);
        wait_done("t3b");

        // 4: back-pressure on both channels; 200 words = 25 beats -> 16 + 9
        ar_stall = 1'b1;
        dat_stall = 1'b1;
        exp_dat.push_back(32'd200);
        push_ar(32'h2000, 4'd15);
        push_ar(32'h2200, 4'd8);
        issue(32'h2000, 32'd200, k);
        wait_done("t4");
        check("t4_dat_edge", dat_edge - k, 4);
        ar_stall = 1'b0;
        dat_stall = 1'b0;
        @(posedge clk);
        #1;

        // 5: zero length is consumed in the IDLE state
        issue(32'h6000, 32'd0, k);
        for (int i = 0; i < 4; i++) begin
            check("t5_idle_outputs", {cfg_ready, busy, dat_valid, axi_arvalid}, 4'b1000);
            @(posedge clk);
            #1;
        end

        // 6: reset while arvalid is held high
        ar_stall = 1'b1;
        exp_dat.push_back(32'd400);
        issue(32'h3000, 32'd400, k);
        n = 0;
        while (!axi_arvalid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_arvalid_seen", axi_arvalid, 1'b1);
        check("t6_dat_consumed", exp_dat.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        ar_stall = 1'b0;
        exp_ar.delete();
        @(posedge clk);
        #1;

        // 6b: a fresh 8-word job after reset -> single beat
        exp_dat.push_back(32'd8);
        push_ar(32'h4000, 4'd0);
        issue(32'h4000, 32'd8, k);
        wait_done("t6b");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
